// File: rtl/nios_led_pio_blink.sv
// Avalon-MM LED output PIO with atomic set/clear/toggle registers.
// Optional per-bit hardware blink engine enabled by defining LED_PIO_BLINK_EN.
module nios_led_pio_blink #(
   parameter int               WIDTH     = 18,
   parameter int               DIV_W     = 24,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic             w_wr;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] r_data;
   logic             w_unused;

   assign w_wr     = chipselect & ~write_n;
   assign w_wd     = writedata[WIDTH-1:0];
   assign w_unused = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= RESET_VAL;
      end else if (w_wr) begin
         case (address)
            3'd0:    r_data <= w_wd;
            3'd4:    r_data <= r_data | w_wd;
            3'd5:    r_data <= r_data & ~w_wd;
            3'd6:    r_data <= r_data ^ w_wd;
            default: r_data <= r_data;
         endcase
      end
   end

`ifdef LED_PIO_BLINK_EN
   logic [WIDTH-1:0] r_mask;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic             r_phase;
   logic             w_div_wr;

   assign w_div_wr = w_wr && (address == 3'd2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask <= '0;
      end else if (w_wr && (address == 3'd1)) begin
         r_mask <= w_wd;
      end
   end

   // A DIVISOR write restarts the half-period and beats a same-edge rollover.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div   <= '0;
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (w_div_wr) begin
         r_div   <= writedata[DIV_W-1:0];
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (r_div == '0) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (r_cnt == r_div) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + DIV_W'(1);
      end
   end

   assign out_port = r_data & ~(r_mask & {WIDTH{r_phase}});

   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0:    readdata = 32'(r_data);
         3'd1:    readdata = 32'(r_mask);
         3'd2:    readdata = 32'(r_div);
         3'd7:    readdata = {31'd0, r_phase};
         default: readdata = 32'd0;
      endcase
   end
`else
   assign out_port = r_data;

   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0:    readdata = 32'(r_data);
         default: readdata = 32'd0;
      endcase
   end
`endif

endmodule
